delay_line_reg: RTL and testbench
=================================

# delay_line_reg

Parametrised, clock-enabled delay-line register with per-stage valid tracking, runtime-selectable output tap, occupancy count and an optional registered sample-difference output. It is the multi-stage successor to the single-stage reset register. It sits between sample sources and downstream arithmetic wherever a programmable D-sample delay or an x[n] − x[n−D] term is required.

## Interface
- REG_SIZE, 4, data width in bits (≥1)
- DEPTH, 4, number of delay stages (≥2)
- TAP_W, $clog2(DEPTH), derived, tap-select width
- CNT_W, $clog2(DEPTH+1), derived, count width
- clk_80  in  1  clock, all state updates on rising edge
- rst_80  in  1  reset, asynchronous, active-high
- en_80  in  1  shift enable; 0 holds all state
- clr_80  in  1  synchronous clear of all stages, valids, count, diff
- in_valid_80  in  1  qualifies d_80
- d_80  in  REG_SIZE  input sample
- tap_80  in  TAP_W  output tap; delay = tap_80+1 enabled cycles
- q_80  out  REG_SIZE  delayed sample stage[tap]
- q_valid_80  out  1  valid bit of stage[tap]
- primed_80  out  1  all DEPTH stages hold valid data
- count_80  out  CNT_W  number of valid stages
- diff_80  out  REG_SIZE+1  registered difference, two's complement (only with macro)
- diff_valid_80  out  1  qualifies diff_80 (only with macro)

## Operation
- Storage: stage[0..DEPTH-1] (REG_SIZE each), vld[0..DEPTH-1].
- Enabled edge (en_80=1, clr_80=0): stage[0]<=d_80, vld[0]<=in_valid_80; stage[i]<=stage[i-1], vld[i]<=vld[i-1]. Invalid samples shift like valid ones (data kept, valid 0).
- en_80=0, clr_80=0: all registers hold.
- clr_80=1: all stages, valids, count, diff regs to 0 regardless of en_80 (clr wins).
- q_80/q_valid_80: combinational mux of registered stage[tap]/vld[tap]; a tap change takes effect in the same cycle. tap_80 ≥ DEPTH (non-power-of-2 DEPTH) clamps to DEPTH-1.
- count_80: registered; on enabled edge count <= count + in_valid_80 − vld[DEPTH-1]. Always equals popcount(vld); never exceeds DEPTH or underflows.
- primed_80 = (count_80 == DEPTH).
- diff (macro on): on enabled edge diff_80 <= {1'b0,d_80} − {1'b0,stage[tap]}, i.e. x[n] − x[n−(tap+1)], result REG_SIZE+1 bits, wraps mod 2^(REG_SIZE+1) (never truncates for unsigned inputs); diff_valid_80 <= in_valid_80 & vld[tap]. Holds when en_80=0.

## Timing
- Reset (rst_80 asserted, any time incl. mid-stream): all stages, vld, count_80, diff_80, diff_valid_80 = 0 immediately; hence q_80=0, q_valid_80=0, primed_80=0.
- Latency d_80 → q_80: tap_80+1 enabled edges; disabled cycles do not count.
- Latency d_80 → diff_80: 1 enabled edge.
- Simultaneous in_valid_80=1 and vld[DEPTH-1]=1 on enabled edge: count unchanged.
- rst_80 deassertion is synchronised upstream; block takes no action on release.

## Configuration
- DELAY_LINE_DIFF_OUT_EN defined: diff_80, diff_valid_80 ports and subtractor/registers present.
- Undefined: those ports and logic absent; all other behaviour identical.

## Structure
- Shared package delay_line_pkg: tap clamp function, CNT_W/TAP_W derivation functions, typedef for a sample word parameterised by REG_SIZE via localparam in module.
- One sub-module dl_stage: single REG_SIZE-bit data + valid register with async reset, enable and sync clear; instantiated DEPTH times via generate.

## Test plan
- REG_SIZE=4, DEPTH=4: rst_80 pulsed after 3 valid pushes → q_80=0, count_80=0, primed_80=0, diff_80=0 same cycle.
- tap_80=3, push 1,2,3,4,5 (valid, en=1) → q_80=1 after 4th edge, 2 after 5th; tap_80 switched to 0 → q_80=5 immediately.
- Push 4 valid samples → count_80=4, primed_80=1; then in_valid_80=0 for 2 edges → count_80=2, primed_80=0.
- en_80=0 for 5 cycles mid-stream → q_80, count_80 unchanged; clr_80=1 with en_80=0 → count_80=0, q_valid_80=0 next edge.
- Macro on, tap_80=1: push 2,5,9 → diff_80=7 (5'b00111), diff_valid_80=1 after 3rd edge; push 15,x,0 → diff_80=−15 (5'b10001).
- Invalid sample in middle of stream, tap_80=1 → q_valid_80 low exactly one cycle, 2 edges later; diff_valid_80 low when either operand invalid.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared helpers for the delay line: tap/count width derivation and tap clamping.
package delay_line_pkg;

  function automatic int tap_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w_f(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A tap beyond the last stage (non-power-of-2 depth) selects the last stage.
  function automatic int unsigned clamp_tap(input int unsigned tap, input int unsigned depth);
    return (tap >= depth) ? depth - 1 : tap;
  endfunction

endpackage

// File: rtl/delay_line_reg_stage.sv
// One delay stage: REG_SIZE data bits plus valid, async reset, enable, sync clear.
module dl_stage #(
  parameter int REG_SIZE = 4
) (
  input  logic                clk_80,
  input  logic                rst_80,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [REG_SIZE-1:0] d_i,
  input  logic                v_i,
  output logic [REG_SIZE-1:0] d_o,
  output logic                v_o
);
  logic [REG_SIZE-1:0] d_q;
  logic                v_q;

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (clr_i) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (en_i) begin
      d_q <= d_i;
      v_q <= v_i;
    end
  end

  assign d_o = d_q;
  assign v_o = v_q;
endmodule

// File: rtl/delay_line_reg.sv
// Clock-enabled delay line with per-stage valids, selectable tap and occupancy count.
// Define DELAY_LINE_DIFF_OUT_EN to add the registered x[n] - x[n-(tap+1)] output.
module delay_line_reg
  import delay_line_pkg::*;
#(
  parameter int REG_SIZE = 4,
  parameter int DEPTH    = 4,
  parameter int TAP_W    = tap_w_f(DEPTH),
  parameter int CNT_W    = cnt_w_f(DEPTH)
) (
  input  logic                clk_80,
  input  logic                rst_80,
  input  logic                en_80,
  input  logic                clr_80,
  input  logic                in_valid_80,
  input  logic [REG_SIZE-1:0] d_80,
  input  logic [TAP_W-1:0]    tap_80,
  output logic [REG_SIZE-1:0] q_80,
  output logic                q_valid_80,
  output logic                primed_80,
  output logic [CNT_W-1:0]    count_80
`ifdef DELAY_LINE_DIFF_OUT_EN
  ,
  output logic [REG_SIZE:0]   diff_80,
  output logic                diff_valid_80
`endif
);
  typedef logic [REG_SIZE-1:0] sample_t;

  sample_t [DEPTH-1:0] stage_q;
  logic    [DEPTH-1:0] vld_q;
  logic    [TAP_W-1:0] tap_sel;
  logic    [CNT_W-1:0] count_q, count_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    sample_t din;
    logic    vin;
    if (g == 0) begin : g_head
      assign din = d_80;
      assign vin = in_valid_80;
    end else begin : g_body
      assign din = stage_q[g-1];
      assign vin = vld_q[g-1];
    end
    dl_stage #(.REG_SIZE(REG_SIZE)) u_stage (
      .clk_80 (clk_80),
      .rst_80 (rst_80),
      .en_i   (en_80),
      .clr_i  (clr_80),
      .d_i    (din),
      .v_i    (vin),
      .d_o    (stage_q[g]),
      .v_o    (vld_q[g])
    );
  end

  assign tap_sel    = TAP_W'(clamp_tap(32'(tap_80), DEPTH));
  assign q_80       = stage_q[tap_sel];
  assign q_valid_80 = vld_q[tap_sel];

  // Entering valid and leaving valid cancel; the count tracks popcount(vld) exactly.
  always_comb begin
    count_d = count_q;
    if (clr_80)
      count_d = '0;
    else if (en_80)
      count_d = count_q + CNT_W'(in_valid_80) - CNT_W'(vld_q[DEPTH-1]);
  end

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_80  = count_q;
  assign primed_80 = (count_q == CNT_W'(DEPTH));

`ifdef DELAY_LINE_DIFF_OUT_EN
  logic [REG_SIZE:0] diff_q, diff_d;
  logic              diff_valid_q, diff_valid_d;

  always_comb begin
    diff_d       = diff_q;
    diff_valid_d = diff_valid_q;
    if (clr_80) begin
      diff_d       = '0;
      diff_valid_d = 1'b0;
    end else if (en_80) begin
      diff_d       = {1'b0, d_80} - {1'b0, stage_q[tap_sel]};
      diff_valid_d = in_valid_80 & vld_q[tap_sel];
    end
  end

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
    end else begin
      diff_q       <= diff_d;
      diff_valid_q <= diff_valid_d;
    end
  end

  assign diff_80       = diff_q;
  assign diff_valid_80 = diff_valid_q;
`endif
endmodule

// File: tb/tb_delay_line_reg.sv
// Self-checking bench for delay_line_reg (REG_SIZE=4, DEPTH=4); checks diff only when
// DELAY_LINE_DIFF_OUT_EN is defined.
module tb_delay_line_reg;
  logic       clk_80 = 1'b0;
  logic       rst_80 = 1'b1;
  logic       en_80 = 1'b0, clr_80 = 1'b0, in_valid_80 = 1'b0;
  logic [3:0] d_80 = '0;
  logic [1:0] tap_80 = '0;
  logic [3:0] q_80;
  logic       q_valid_80, primed_80;
  logic [2:0] count_80;
`ifdef DELAY_LINE_DIFF_OUT_EN
  logic [4:0] diff_80;
  logic       diff_valid_80;
`endif

  always #5 clk_80 = ~clk_80;

  delay_line_reg #(.REG_SIZE(4), .DEPTH(4)) dut (
    .clk_80(clk_80), .rst_80(rst_80), .en_80(en_80), .clr_80(clr_80),
    .in_valid_80(in_valid_80), .d_80(d_80), .tap_80(tap_80),
    .q_80(q_80), .q_valid_80(q_valid_80), .primed_80(primed_80), .count_80(count_80)
`ifdef DELAY_LINE_DIFF_OUT_EN
    , .diff_80(diff_80), .diff_valid_80(diff_valid_80)
`endif
  );

  typedef struct {
    logic       en, clr, iv;
    logic [3:0] d;
    logic [1:0] tap;
    logic [3:0] eq;
    logic       eqv;
    logic [2:0] ecnt;
    logic       epr;
    logic [4:0] ediff;
    logic       edv;
  } vec_t;

  typedef struct { logic v; logic [3:0] d; } samp_t;

  int n_cmp = 0, n_err = 0;
  vec_t  vecs[$];
  samp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int en, clr, iv, d, tap, q, qv, cnt, pr, df, dv);
    vec_t v;
    v.en = 1'(en); v.clr = 1'(clr); v.iv = 1'(iv); v.d = 4'(d); v.tap = 2'(tap);
    v.eq = 4'(q); v.eqv = 1'(qv); v.ecnt = 3'(cnt); v.epr = 1'(pr);
    v.ediff = 5'(df); v.edv = 1'(dv);
    return v;
  endfunction

  task automatic chk_diff(input string tag, input int df, input int dv);
`ifdef DELAY_LINE_DIFF_OUT_EN
    chk({tag, ".diff"}, int'(diff_80), df);
    chk({tag, ".diff_valid"}, int'(diff_valid_80), dv);
`endif
  endtask

  initial begin
    logic [3:0] hist;
    //          en clr iv  d tap   q qv cnt pr diff dv
    vecs.push_back(mkv(1, 0, 1,  1, 3,  0, 0, 1, 0,  1, 0));
    vecs.push_back(mkv(1, 0, 1,  2, 3,  0, 0, 2, 0,  2, 0));
    vecs.push_back(mkv(1, 0, 1,  3, 3,  0, 0, 3, 0,  3, 0));
    vecs.push_back(mkv(1, 0, 1,  4, 3,  1, 1, 4, 1,  4, 0));
    vecs.push_back(mkv(1, 0, 1,  5, 3,  2, 1, 4, 1,  4, 1));
    vecs.push_back(mkv(0, 0, 0,  0, 0,  5, 1, 4, 1,  4, 1));  // tap change, no edge needed
    vecs.push_back(mkv(1, 0, 0,  6, 3,  3, 1, 3, 0,  4, 0));
    vecs.push_back(mkv(1, 0, 0,  7, 3,  4, 1, 2, 0,  4, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(0, 0, 1,  9, 3,  4, 1, 2, 0,  4, 0));
    vecs.push_back(mkv(0, 1, 1,  9, 3,  0, 0, 0, 0,  0, 0));  // clear wins over en=0
    vecs.push_back(mkv(1, 0, 1,  1, 1,  0, 0, 1, 0,  1, 0));
    vecs.push_back(mkv(1, 0, 1,  2, 1,  1, 1, 2, 0,  2, 0));
    vecs.push_back(mkv(1, 0, 0,  3, 1,  2, 1, 2, 0,  2, 0));
    vecs.push_back(mkv(1, 0, 1,  4, 1,  3, 0, 3, 0,  2, 1));
    vecs.push_back(mkv(1, 0, 1,  5, 1,  4, 1, 3, 0,  2, 0));
    vecs.push_back(mkv(1, 0, 1,  6, 1,  5, 1, 3, 0,  2, 1));
    vecs.push_back(mkv(1, 0, 1,  7, 1,  6, 1, 4, 1,  2, 1));
    vecs.push_back(mkv(1, 1, 1,  7, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mkv(1, 0, 1,  2, 1,  0, 0, 1, 0,  2, 0));
    vecs.push_back(mkv(1, 0, 1,  5, 1,  2, 1, 2, 0,  5, 0));
    vecs.push_back(mkv(1, 0, 1,  9, 1,  5, 1, 3, 0,  7, 1));
    vecs.push_back(mkv(1, 0, 1, 15, 1,  9, 1, 4, 1, 10, 1));
    vecs.push_back(mkv(1, 0, 1,  3, 1, 15, 1, 4, 1, 26, 1));  // 3-9 wraps to 5'b11010
    vecs.push_back(mkv(1, 0, 1,  0, 1,  3, 1, 4, 1, 17, 1));  // 0-15 = 5'b10001
    vecs.push_back(mkv(1, 0, 1,  8, 1,  0, 1, 4, 1,  5, 1));

    // reset state
    repeat (2) @(posedge clk_80);
    #1;
    chk("rst.q", int'(q_80), 0);
    chk("rst.q_valid", int'(q_valid_80), 0);
    chk("rst.count", int'(count_80), 0);
    chk("rst.primed", int'(primed_80), 0);
    chk_diff("rst", 0, 0);
    @(negedge clk_80) rst_80 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_80);
      en_80 = vecs[i].en; clr_80 = vecs[i].clr; in_valid_80 = vecs[i].iv;
      d_80 = vecs[i].d; tap_80 = vecs[i].tap;
      @(posedge clk_80);
      #1;
      chk($sformatf("vec%0d.q", i), int'(q_80), int'(vecs[i].eq));
      chk($sformatf("vec%0d.q_valid", i), int'(q_valid_80), int'(vecs[i].eqv));
      chk($sformatf("vec%0d.count", i), int'(count_80), int'(vecs[i].ecnt));
      chk($sformatf("vec%0d.primed", i), int'(primed_80), int'(vecs[i].epr));
      chk_diff($sformatf("vec%0d", i), int'(vecs[i].ediff), int'(vecs[i].edv));
    end

    // asynchronous reset mid-stream, away from any edge
    @(negedge clk_80);
    en_80 = 1'b1; clr_80 = 1'b1;
    @(negedge clk_80);
    clr_80 = 1'b0; in_valid_80 = 1'b1; tap_80 = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      d_80 = 4'(i + 10);
      @(negedge clk_80);
    end
    en_80 = 1'b0;
    chk("pre_rst.q", int'(q_80), 13);
    chk("pre_rst.count", int'(count_80), 3);
    #2 rst_80 = 1'b1;
    #1;
    chk("midrst.q", int'(q_80), 0);
    chk("midrst.q_valid", int'(q_valid_80), 0);
    chk("midrst.count", int'(count_80), 0);
    chk("midrst.primed", int'(primed_80), 0);
    chk_diff("midrst", 0, 0);
    @(negedge clk_80) rst_80 = 1'b0;

    // scoreboard: random enable/valid stream at tap 2 (3 enabled edges of latency)
    hist = '0;
    tap_80 = 2'd2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_80);
      en_80 = ($urandom_range(0, 3) != 0);
      in_valid_80 = ($urandom_range(0, 3) != 0);
      d_80 = 4'($urandom_range(0, 15));
      @(posedge clk_80);
      #1;
      if (en_80) begin
        sb.push_back('{v: in_valid_80, d: d_80});
        hist = {hist[2:0], in_valid_80};
        if (sb.size() == 3) begin
          chk("sb.q", int'(q_80), int'(sb[0].d));
          chk("sb.q_valid", int'(q_valid_80), int'(sb[0].v));
          void'(sb.pop_front());
        end
      end
      chk("sb.count", int'(count_80), $countones(hist));
      chk("sb.primed", int'(primed_80), int'(hist == 4'hF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
